// File: rtl/dram_result_reader_pkg.sv
// Shared constants and FSM encoding for the DRAM result readout path.
// Also used by the DRAM controller and the testbench.
package dram_result_reader_pkg;

    localparam int unsigned DEF_ADDR_W   = 16;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_HDR_ADDR = 12;
    localparam int unsigned DEF_END_ADDR = 511;
    localparam int unsigned DEF_N_CORES  = 4;

    // ST_CSUM is only reachable when RESULT_READER_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_RD = 3'd1,
        ST_HDR_WT = 3'd2,
        ST_DAT_RD = 3'd3,
        ST_DAT_WT = 3'd4,
        ST_SEND   = 3'd5,
        ST_CSUM   = 3'd6,
        ST_FIN    = 3'd7
    } state_e;

endpackage

// File: rtl/dram_result_reader_if.sv
// DRAM read port plus outgoing byte stream of the result reader.
// master = reader side, slave = DRAM model / stream sink side.
interface dram_result_reader_if #(
    parameter int unsigned ADDR_W = dram_result_reader_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = dram_result_reader_pkg::DEF_DATA_W
);
    logic              o_dram_rd;
    logic [ADDR_W-1:0] o_dram_addr;
    logic [DATA_W-1:0] i_dram_data;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_last;

    modport master (
        output o_dram_rd, o_dram_addr, o_data, o_valid, o_last,
        input  i_dram_data, i_ready
    );

    modport slave (
        input  o_dram_rd, o_dram_addr, o_data, o_valid, o_last,
        output i_dram_data, i_ready
    );
endinterface

// File: rtl/dram_result_reader.sv
// Reads result matrix C from DRAM (base taken from the header byte) up to
// END_ADDR inclusive and streams it out as bytes over valid/ready.
// Optional macro RESULT_READER_CHECKSUM_EN appends a two's-complement
// checksum byte so that all streamed bytes sum to 0 mod 256.
module dram_result_reader #(
    parameter int unsigned ADDR_W   = dram_result_reader_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W   = dram_result_reader_pkg::DEF_DATA_W,
    parameter int unsigned HDR_ADDR = dram_result_reader_pkg::DEF_HDR_ADDR,
    parameter int unsigned END_ADDR = dram_result_reader_pkg::DEF_END_ADDR,
    parameter int unsigned N_CORES  = dram_result_reader_pkg::DEF_N_CORES
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [N_CORES-1:0]        i_cores_busy,
    dram_result_reader_if.master      rd_bus,
    output logic                      o_busy,
    output logic                      o_done
);
    import dram_result_reader_pkg::*;

    localparam logic [ADDR_W-1:0] HDR_A = ADDR_W'(HDR_ADDR);
    localparam logic [ADDR_W-1:0] END_A = ADDR_W'(END_ADDR);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hs_c;
`ifdef RESULT_READER_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
`endif

    assign hs_c = valid_q & rd_bus.i_ready;

    // Next state, pointer/data updates, and registered outputs derived from next state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        addr_d  = addr_q;
`ifdef RESULT_READER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start && (i_cores_busy == '0)) begin
                    state_d = ST_HDR_RD;
`ifdef RESULT_READER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ST_HDR_RD: state_d = ST_HDR_WT;
            ST_HDR_WT: begin
                ptr_d = ADDR_W'(rd_bus.i_dram_data);
                if (ptr_d > END_A) begin
`ifdef RESULT_READER_CHECKSUM_EN
                    data_d  = '0;
                    state_d = ST_CSUM;
`else
                    state_d = ST_FIN;
`endif
                end else begin
                    state_d = ST_DAT_RD;
                end
            end
            ST_DAT_RD: state_d = ST_DAT_WT;
            ST_DAT_WT: begin
                data_d  = rd_bus.i_dram_data;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (hs_c) begin
`ifdef RESULT_READER_CHECKSUM_EN
                    sum_d = sum_q + data_q;
`endif
                    if (ptr_q == END_A) begin
`ifdef RESULT_READER_CHECKSUM_EN
                        data_d  = ~sum_d + DATA_W'(1);
                        state_d = ST_CSUM;
`else
                        state_d = ST_FIN;
`endif
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = ST_DAT_RD;
                    end
                end
            end
`ifdef RESULT_READER_CHECKSUM_EN
            ST_CSUM: begin
                if (hs_c) state_d = ST_FIN;
            end
`endif
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        rd_d = (state_d == ST_HDR_RD) || (state_d == ST_DAT_RD);
        if (state_d == ST_HDR_RD) addr_d = HDR_A;
        else if (state_d == ST_DAT_RD) addr_d = ptr_d;
        valid_d = (state_d == ST_SEND) || (state_d == ST_CSUM);
`ifdef RESULT_READER_CHECKSUM_EN
        last_d  = (state_d == ST_CSUM);
`else
        last_d  = (state_d == ST_SEND) && (ptr_d == END_A);
`endif
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_FIN);
        done_d  = (state_d == ST_FIN);
    end

    // State and output registers; reset aborts any stream in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RESULT_READER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef RESULT_READER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign rd_bus.o_dram_rd   = rd_q;
    assign rd_bus.o_dram_addr = addr_q;
    assign rd_bus.o_data      = data_q;
    assign rd_bus.o_valid     = valid_q;
    assign rd_bus.o_last      = last_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;

endmodule

// File: tb/tb_dram_result_reader.sv
// Directed bench for dram_result_reader with a small DRAM model and stream monitor.
// END_ADDR is overridden to 0xFE so that 8-bit header bases can reach and exceed it.
module tb_dram_result_reader;

    localparam int unsigned END_A = 254;
    localparam int unsigned HDR_A = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] cores_busy;
    logic       busy;
    logic       done;

    dram_result_reader_if #(.ADDR_W(16), .DATA_W(8)) dif ();

    dram_result_reader #(
        .ADDR_W(16), .DATA_W(8), .HDR_ADDR(HDR_A), .END_ADDR(END_A), .N_CORES(4)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_cores_busy(cores_busy),
        .rd_bus(dif.master), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:511];
    logic [7:0] got_q[$];
    logic       got_last_q[$];
    int         n_chk = 0;
    int         n_bad = 0;
    int         n_rd = 0;
    int         n_done = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    int         done_cyc = 0;
    logic       stall_pend = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // DRAM model: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (dif.o_dram_rd) dif.i_dram_data <= mem[dif.o_dram_addr[8:0]];
    end

    // Stream monitor: logs handshakes, counts strobes and checks stall stability.
    always @(posedge clk) begin
        if (!rst) begin
            if (stall_pend) chk("hold", 32'({dif.o_valid, dif.o_data}), 32'({1'b1, stall_data}));
            if (dif.o_valid && dif.i_ready) begin
                got_q.push_back(dif.o_data);
                got_last_q.push_back(dif.o_last);
                if (dif.o_last) last_cyc = cyc;
            end
            if (dif.o_dram_rd) n_rd++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            stall_pend = dif.o_valid && !dif.i_ready;
            stall_data = dif.o_data;
        end else begin
            stall_pend = 1'b0;
        end
        cyc = cyc + 1;
    end

    // Expected stream is mem[base..END_A], plus the two's-complement checksum byte if enabled.
    task automatic check_stream(input string tag, input int base);
        logic [7:0] e[$];
        logic [7:0] s;
        s = 8'h00;
        for (int a = base; a <= int'(END_A); a++) begin
            e.push_back(mem[a]);
            s = s + mem[a];
        end
`ifdef RESULT_READER_CHECKSUM_EN
        e.push_back(~s + 8'h01);
`endif
        chk({tag, "_n"}, 32'(got_q.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < got_q.size(); i++) begin
            chk({tag, "_byte"}, 32'(got_q[i]), 32'(e[i]));
            chk({tag, "_last"}, 32'(got_last_q[i]), 32'(i == e.size() - 1));
        end
    endtask

    task automatic wait_done(input string tag, input bit toggle);
        int d0;
        bit ok;
        d0 = n_done;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (toggle) dif.i_ready = ~dif.i_ready;
            if (n_done > d0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_cnt"}, 32'(n_done - d0), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        dif.i_ready = 1'b1;
    endtask

    task automatic run(input string tag, input logic [7:0] hdr, input bit toggle);
        mem[HDR_A] = hdr;
        got_q.delete();
        got_last_q.delete();
        @(negedge clk);
        start = 1'b1;
        wait_done(tag, toggle);
        check_stream(tag, int'(hdr));
    endtask

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = 8'(a ^ 8'h3C);
        for (int i = 0; i < 8; i++) mem[247 + i] = 8'(8'h10 + i);
        rst = 1'b1;
        start = 1'b0;
        cores_busy = 4'b0000;
        dif.i_ready = 1'b0;
        dif.i_dram_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rd",    32'(dif.o_dram_rd),   32'd0);
        chk("rst_addr",  32'(dif.o_dram_addr), 32'd0);
        chk("rst_valid", 32'(dif.o_valid),     32'd0);
        chk("rst_last",  32'(dif.o_last),      32'd0);
        chk("rst_data",  32'(dif.o_data),      32'd0);
        chk("rst_busy",  32'(busy),            32'd0);
        chk("rst_done",  32'(done),            32'd0);
        rst = 1'b0;
        dif.i_ready = 1'b1;
        @(negedge clk);

        // 1: eight bytes 0x10..0x17 from base 0xF7, o_done one cycle after last handshake
        run("t1", 8'hF7, 1'b0);
        if (got_q.size() > 0) chk("t1_first", 32'(got_q[0]), 32'h10);
        chk("t1_done_lat", 32'(done_cyc - last_cyc), 32'd1);

        // 2: start held while a core is busy; no reads until busy clears
        n_rd = 0;
        got_q.delete();
        got_last_q.delete();
        start = 1'b1;
        cores_busy = 4'b0100;
        repeat (50) @(negedge clk);
        chk("t2_no_rd", 32'(n_rd), 32'd0);
        chk("t2_idle",  32'(busy), 32'd0);
        cores_busy = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        chk("t2_rd",   32'(dif.o_dram_rd),   32'd1);
        chk("t2_addr", 32'(dif.o_dram_addr), 32'(HDR_A));
        chk("t2_busy", 32'(busy),            32'd1);
        wait_done("t2", 1'b0);
        check_stream("t2", 247);

        // 3: last two bytes with i_ready toggling every cycle
        mem[253] = 8'hA5;
        mem[254] = 8'h5A;
        run("t3", 8'hFD, 1'b1);

        // 4: base at END_ADDR gives one byte; base beyond gives an empty stream
        run("t4a", 8'hFE, 1'b0);
        run("t4b", 8'hFF, 1'b0);

        // 5: reset during SEND of the third byte aborts, then a fresh run starts at the header
        for (int i = 0; i < 8; i++) mem[247 + i] = 8'(8'h10 + i);
        mem[HDR_A] = 8'hF7;
        got_q.delete();
        got_last_q.delete();
        @(negedge clk);
        start = 1'b1;
        begin
            bit hit;
            hit = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                start = 1'b0;
                if (dif.o_valid && got_q.size() == 2) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("t5_third_send", 32'(hit), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t5_valid", 32'(dif.o_valid), 32'd0);
        chk("t5_busy",  32'(busy),        32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_nbytes", 32'(got_q.size()), 32'd2);
        chk("t5_quiet",  32'(dif.o_valid),  32'd0);
        got_q.delete();
        got_last_q.delete();
        start = 1'b1;
        @(negedge clk);
        chk("t5_hdr_rd",   32'(dif.o_dram_rd),   32'd1);
        chk("t5_hdr_addr", 32'(dif.o_dram_addr), 32'(HDR_A));
        wait_done("t5", 1'b0);
        check_stream("t5", 247);

        // 6: bytes 01,02,03; with checksum enabled a fourth byte 0xFA carries o_last
        mem[252] = 8'h01;
        mem[253] = 8'h02;
        mem[254] = 8'h03;
        run("t6", 8'hFC, 1'b0);
`ifdef RESULT_READER_CHECKSUM_EN
        if (got_q.size() == 4) chk("t6_csum", 32'(got_q[3]), 32'hFA);
        else chk("t6_len", 32'(got_q.size()), 32'd4);
`else
        if (got_q.size() == 3) chk("t6_lastbyte", 32'(got_q[2]), 32'h03);
        else chk("t6_len", 32'(got_q.size()), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
